// File: rtl/pwm_capture.sv
// PWM capture: synchronizes iPWM, measures high time and period in cycles, reports normalized duty.
// Define PWM_CAPTURE_DUTY_EN to build the sequential duty divider; otherwise oDuty is tied to 0.
//
// state | meaning
// IDLE  | waiting for a rise (after reset or timeout); falls ignored
// HIGH  | input high, counting high time
// LOW   | input low, counting remainder of the period
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             iCLK,
  input  logic             iReset,
  input  logic             iPWM,
  output logic [CNT_W-1:0] oHigh,
  output logic [CNT_W-1:0] oPeriod,
  output logic [11:0]      oDuty,
  output logic             oValid,
  output logic             oTimeout,
  output logic             oLevel
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} stateT;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic             s1, s2, s3;
  logic             s1Real, s2Real, armed;
  logic             rise, fall, atLimit, divBusy;
  stateT            state;
  logic [CNT_W-1:0] cnt, hiLat, perLat;
  logic             pubReq;

  // armed blocks a rise until the synchronized input has really been seen low
  always_ff @(posedge iCLK) begin
    if (iReset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      s1Real <= 1'b0;
      s2Real <= 1'b0;
      armed  <= 1'b0;
    end else begin
      s1     <= iPWM;
      s2     <= s1;
      s3     <= s2;
      s1Real <= 1'b1;
      s2Real <= s1Real;
      if (s2Real && !s2) armed <= 1'b1;
    end
  end

  assign rise    = armed & s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign oLevel  = s2;
  assign atLimit = (cnt == TIMEOUT_CNT);

`ifdef PWM_CAPTURE_DUTY_EN
  logic             busy, sat, qBit;
  logic [CNT_W:0]   rem, remShift, remSub;
  logic [CNT_W-1:0] dHigh, dPeriod;
  logic [10:0]      quot;
  logic [3:0]       bitIdx;

  assign divBusy  = busy | pubReq;
  assign remShift = rem << 1;
  assign remSub   = remShift - {1'b0, dPeriod};
  assign qBit     = (remShift >= {1'b0, dPeriod});
`else
  assign divBusy = 1'b0;
  assign oDuty   = '0;
`endif

  always_ff @(posedge iCLK) begin
    if (iReset) begin
      state    <= IDLE;
      cnt      <= '0;
      hiLat    <= '0;
      perLat   <= '0;
      pubReq   <= 1'b0;
      oHigh    <= '0;
      oPeriod  <= '0;
      oValid   <= 1'b0;
      oTimeout <= 1'b0;
`ifdef PWM_CAPTURE_DUTY_EN
      busy     <= 1'b0;
      sat      <= 1'b0;
      rem      <= '0;
      dHigh    <= '0;
      dPeriod  <= '0;
      quot     <= '0;
      bitIdx   <= '0;
      oDuty    <= '0;
`endif
    end else begin
      oValid <= 1'b0;
      pubReq <= 1'b0;
`ifdef PWM_CAPTURE_DUTY_EN
      // load cycle snapshots the latches, then 12 restoring steps of hi*4096/per
      if (pubReq) begin
        rem     <= {1'b0, hiLat};
        dHigh   <= hiLat;
        dPeriod <= perLat;
        sat     <= (hiLat >= perLat);
        quot    <= '0;
        bitIdx  <= 4'd11;
        busy    <= 1'b1;
      end else if (busy) begin
        rem    <= qBit ? remSub : remShift;
        quot   <= {quot[9:0], qBit};
        bitIdx <= bitIdx - 4'd1;
        if (bitIdx == 4'd0) begin
          busy    <= 1'b0;
          oHigh   <= dHigh;
          oPeriod <= dPeriod;
          oDuty   <= sat ? 12'hFFF : {quot, qBit};
          oValid  <= 1'b1;
        end
      end
`else
      if (pubReq) begin
        oHigh   <= hiLat;
        oPeriod <= perLat;
        oValid  <= 1'b1;
      end
`endif
      if (atLimit && !rise && !oTimeout) begin
        oTimeout <= 1'b1;
        state    <= IDLE;
`ifdef PWM_CAPTURE_DUTY_EN
        busy   <= 1'b0;
        oDuty  <= {12{s2}};
        oValid <= 1'b1;
`endif
      end else begin
        if (!atLimit) cnt <= cnt + 1'b1;
        case (state)
          IDLE: begin
            if (rise) begin
              cnt      <= CNT_W'(1);
              state    <= HIGH;
              oTimeout <= 1'b0;
            end
          end
          HIGH: begin
            if (fall) begin
              hiLat <= cnt;
              state <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              perLat <= cnt;
              cnt    <= CNT_W'(1);
              state  <= HIGH;
              if (!divBusy) pubReq <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
